// File: rtl/iob_eth_rx_frame_ring_pkg.sv
// Shared types and helpers for the RX frame ring.
// Provides the write-FSM state encoding and the byte-lane select width helper.
package iob_eth_rx_frame_ring_pkg;

  // Write-side frame FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  // Number of address bits that select a byte lane inside a host word
  function automatic int unsigned byte_sel_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob_eth_frame_ram.sv
// Simple dual-port frame RAM: byte-enable write port, registered read port.
// Ports:
//   clk, rst        clock, async active-high reset (read register only)
//   clr_i           synchronous clear of the read data register
//   we_i/wstrb_i    write enable and per-byte strobes
//   waddr_i/wdata_i write word address and data
//   re_i/raddr_i    read enable and word address
//   rdata_o         read data, one cycle after re_i, holds otherwise
module iob_eth_frame_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane write; array has no reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_eth_rx_frame_ring.sv
// Multi-slot RX frame buffer: stores whole received frames in a ring of
// 2^NSLOTS_W slots, discards bad/runt/oversize frames and presents committed
// frames in arrival order to the host/DMA side.
// Ports:
//   clk, rst                  clock, async active-high reset
//   soft_rst_i                synchronous clear of pointers, counters, FSM
//   in_valid_i/in_data_i      receive byte stream (no back-pressure)
//   in_last_i/in_err_i        end of frame and its error flag
//   frame_avail_o             a committed frame is at the read pointer
//   frame_len_o               byte length of that frame
//   rd_en_i/rd_addr_i         word read within the current read slot
//   rd_data_o                 read data, one cycle latency
//   release_i                 pop the frame at the read pointer
//   used_o                    committed frame count
//   drop_cnt_o/err_cnt_o      saturating drop (full/oversize) and error (err/runt) counters
module iob_eth_rx_frame_ring
  import iob_eth_rx_frame_ring_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NSLOTS_W = 2,
  parameter int unsigned SLOT_W   = 11,
  parameter int unsigned MIN_LEN  = 60,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   soft_rst_i,
  input  logic                                   in_valid_i,
  input  logic [7:0]                             in_data_i,
  input  logic                                   in_last_i,
  input  logic                                   in_err_i,
  output logic                                   frame_avail_o,
  output logic [SLOT_W-1:0]                      frame_len_o,
  input  logic                                   rd_en_i,
  input  logic [SLOT_W-byte_sel_w(DATA_W)-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]                      rd_data_o,
  input  logic                                   release_i,
  output logic [NSLOTS_W:0]                      used_o,
  output logic [CNT_W-1:0]                       drop_cnt_o,
  output logic [CNT_W-1:0]                       err_cnt_o
);

  localparam int unsigned BYTES      = DATA_W / 8;
  localparam int unsigned BYTE_SEL_W = byte_sel_w(DATA_W);
  localparam int unsigned RAM_ADDR_W = NSLOTS_W + SLOT_W - BYTE_SEL_W;
  localparam int unsigned NSLOTS     = 1 << NSLOTS_W;
  // Last byte offset that may be written without in_last_i before the frame is oversize
  localparam logic [SLOT_W-1:0] MAX_OFF = SLOT_W'((1 << SLOT_W) - 2);

  wr_state_e            state_q, state_d;
  logic [SLOT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [NSLOTS_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [NSLOTS_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NSLOTS_W:0]    used_q, used_d;
  logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [SLOT_W-1:0]    len_q [NSLOTS];

  logic                 full_c;
  logic                 rel_c;
  logic [SLOT_W-1:0]    wr_off_c;
  logic [SLOT_W-1:0]    len_c;
  logic                 wr_en_c;
  logic                 commit_c;
  logic                 err_inc_c;
  logic                 drop_inc_c;

  assign full_c   = (used_q == (NSLOTS_W+1)'(NSLOTS));
  assign rel_c    = release_i && (used_q != '0);
  assign wr_off_c = (state_q == ST_RECV) ? byte_cnt_q : '0;
  assign len_c    = wr_off_c + SLOT_W'(1);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; a soft reset mid-frame swallows the rest of that frame
  always_comb begin
    state_d = state_q;
    if (soft_rst_i) begin
      if (state_q != ST_IDLE && !(in_valid_i && in_last_i)) state_d = ST_DROP;
      else                                                  state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid_i && !in_last_i) state_d = full_c ? ST_DROP : ST_RECV;
        ST_RECV: begin
          if (in_valid_i) begin
            if (in_last_i)                  state_d = ST_IDLE;
            else if (byte_cnt_q == MAX_OFF) state_d = ST_DROP;
          end
        end
        ST_DROP: if (in_valid_i && in_last_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: byte write, commit/discard decision, byte counter update
  always_comb begin
    wr_en_c    = 1'b0;
    commit_c   = 1'b0;
    err_inc_c  = 1'b0;
    drop_inc_c = 1'b0;
    byte_cnt_d = byte_cnt_q;
    if (soft_rst_i) begin
      byte_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RECV: begin
          if (in_valid_i) begin
            if (state_q == ST_IDLE && full_c) begin
              // Counted once here; DROP never counts again
              drop_inc_c = 1'b1;
            end else begin
              wr_en_c = 1'b1;
              if (in_last_i) begin
                byte_cnt_d = '0;
                if (in_err_i || (len_c < SLOT_W'(MIN_LEN))) err_inc_c = 1'b1;
                else                                         commit_c  = 1'b1;
              end else if (state_q == ST_RECV && byte_cnt_q == MAX_OFF) begin
                drop_inc_c = 1'b1;
                byte_cnt_d = '0;
              end else begin
                byte_cnt_d = len_c;
              end
            end
          end
        end
        default: byte_cnt_d = '0;
      endcase
    end
  end

  // Pointer, occupancy and counter next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q + NSLOTS_W'(commit_c);
    rd_ptr_d   = rd_ptr_q + NSLOTS_W'(rel_c);
    used_d     = used_q + (NSLOTS_W+1)'(commit_c) - (NSLOTS_W+1)'(rel_c);
    drop_cnt_d = (drop_inc_c && (drop_cnt_q != '1)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    err_cnt_d  = (err_inc_c && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    if (soft_rst_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      used_d     = '0;
      drop_cnt_d = '0;
      err_cnt_d  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Per-slot frame length, written on commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSLOTS; s++) len_q[s] <= '0;
    end else if (soft_rst_i) begin
      for (int s = 0; s < NSLOTS; s++) len_q[s] <= '0;
    end else if (commit_c) begin
      len_q[wr_ptr_q] <= len_c;
    end
  end

  iob_eth_frame_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (RAM_ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (soft_rst_i),
    .we_i    (wr_en_c),
    .wstrb_i (BYTES'(1) << wr_off_c[BYTE_SEL_W-1:0]),
    .waddr_i ({wr_ptr_q, wr_off_c[SLOT_W-1:BYTE_SEL_W]}),
    .wdata_i ({BYTES{in_data_i}}),
    .re_i    (rd_en_i),
    .raddr_i ({rd_ptr_q, rd_addr_i}),
    .rdata_o (rd_data_o)
  );

  assign frame_avail_o = (used_q != '0);
  assign frame_len_o   = len_q[rd_ptr_q];
  assign used_o        = used_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_iob_eth_rx_frame_ring.sv
// Self-checking bench for iob_eth_rx_frame_ring (DATA_W=32, 4 slots of 2 KiB).
// A frame-level reference model tracks committed frames and counters;
// read data expectations go through a scoreboard queue.
module tb_iob_eth_rx_frame_ring;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NSLOTS_W = 2;
  localparam int unsigned SLOT_W   = 11;
  localparam int unsigned MIN_LEN  = 60;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned NSLOTS   = 4;
  localparam int unsigned MAX_LEN  = 2047;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              soft_rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_last = 1'b0;
  logic              in_err = 1'b0;
  logic              frame_avail;
  logic [SLOT_W-1:0] frame_len;
  logic              rd_en = 1'b0;
  logic [8:0]        rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              release_r = 1'b0;
  logic [NSLOTS_W:0] used;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  err_cnt;

  always #5 clk = ~clk;

  iob_eth_rx_frame_ring #(
    .DATA_W(DATA_W), .NSLOTS_W(NSLOTS_W), .SLOT_W(SLOT_W),
    .MIN_LEN(MIN_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_i(soft_rst),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_last_i(in_last), .in_err_i(in_err),
    .frame_avail_o(frame_avail), .frame_len_o(frame_len),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .release_i(release_r), .used_o(used),
    .drop_cnt_o(drop_cnt), .err_cnt_o(err_cnt)
  );

  typedef struct {
    int len;
    int base;
  } frame_t;

  frame_t      frames[$];
  logic [31:0] exp_q[$];
  int          exp_drop = 0;
  int          exp_err  = 0;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive one frame byte-per-cycle; optional release on the last byte and soft reset at one byte
  task automatic send_frame(input int len, input int base, input bit err,
                            input bit rel_on_last, input int srst_at);
    bit was_full;
    was_full = (frames.size() == NSLOTS);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = 8'(base + i);
      in_last   = (i == len - 1);
      in_err    = err && (i == len - 1);
      release_r = rel_on_last && (i == len - 1);
      soft_rst  = (i == srst_at);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0; release_r = 1'b0; soft_rst = 1'b0;
    // Reference model of the outcome
    if (srst_at >= 0) begin
      frames.delete();
      exp_drop = 0;
      exp_err  = 0;
    end else begin
      if (rel_on_last && frames.size() > 0) void'(frames.pop_front());
      if (was_full || len > MAX_LEN) exp_drop++;
      else if (err)                  exp_err++;
      else if (len < MIN_LEN)        exp_err++;
      else                           frames.push_back('{len: len, base: base});
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_used"},  32'(used),        32'(frames.size()));
    chk({tag, "_avail"}, 32'(frame_avail), 32'(frames.size() != 0));
    chk({tag, "_drop"},  32'(drop_cnt),    32'(exp_drop));
    chk({tag, "_err"},   32'(err_cnt),     32'(exp_err));
    if (frames.size() != 0) chk({tag, "_len"}, 32'(frame_len), 32'(frames[0].len));
  endtask

  // Read all full words of the head frame through the scoreboard, then release it
  task automatic read_head(input string tag);
    frame_t f;
    logic [31:0] e;
    if (frames.size() == 0) begin
      chk({tag, "_model_nonempty"}, 32'(frame_avail), 32'(0));
      return;
    end
    f = frames[0];
    chk({tag, "_avail"}, 32'(frame_avail), 32'd1);
    chk({tag, "_len"},   32'(frame_len),   32'(f.len));
    for (int w = 0; w < f.len / 4; w++) begin
      e = {8'(f.base + 4*w + 3), 8'(f.base + 4*w + 2), 8'(f.base + 4*w + 1), 8'(f.base + 4*w)};
      exp_q.push_back(e);
      @(negedge clk);
      rd_en = 1'b1; rd_addr = 9'(w);
      @(negedge clk);
      rd_en = 1'b0;
      chk($sformatf("%s_w%0d", tag, w), rd_data, exp_q.pop_front());
    end
    @(negedge clk); release_r = 1'b1;
    @(negedge clk); release_r = 1'b0;
    void'(frames.pop_front());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // Reset state
    chk("rst_avail", 32'(frame_avail), 32'd0);
    chk("rst_len",   32'(frame_len),   32'd0);
    chk("rst_used",  32'(used),        32'd0);
    chk("rst_drop",  32'(drop_cnt),    32'd0);
    chk("rst_err",   32'(err_cnt),     32'd0);
    chk("rst_rdata", rd_data,          32'd0);

    // Single 64-byte frame, bytes 0x00..0x3F
    send_frame(64, 0, 1'b0, 1'b0, -1);
    chk("t1_avail", 32'(frame_avail), 32'd1);
    chk("t1_len",   32'(frame_len),   32'd64);
    @(negedge clk); rd_en = 1'b1; rd_addr = '0;
    @(negedge clk); rd_en = 1'b0;
    chk("t1_word0", rd_data, 32'h03020100);
    check_status("t1");
    read_head("t1");
    check_status("t1_post");

    // Five frames with no release: the fifth is dropped for ring full
    for (int k = 0; k < 5; k++) send_frame(64, 16 * (k + 1), 1'b0, 1'b0, -1);
    check_status("t2");
    chk("t2_used4", 32'(used),     32'd4);
    chk("t2_drop1", 32'(drop_cnt), 32'd1);
    for (int k = 0; k < 4; k++) read_head($sformatf("t2_f%0d", k));
    check_status("t2_post");

    // Errored frame then runt: both counted as errors
    send_frame(64, 32, 1'b1, 1'b0, -1);
    send_frame(40, 48, 1'b0, 1'b0, -1);
    check_status("t3");
    chk("t3_err2", 32'(err_cnt), 32'd2);

    // Oversize frame dropped once, next frame reuses the slot
    send_frame(2100, 5, 1'b0, 1'b0, -1);
    check_status("t4_over");
    send_frame(100, 100, 1'b0, 1'b0, -1);
    check_status("t4");
    chk("t4_len100", 32'(frame_len), 32'd100);
    read_head("t4");

    // Commit and release in the same cycle with two frames held
    send_frame(64, 128, 1'b0, 1'b0, -1);
    send_frame(70, 144, 1'b0, 1'b0, -1);
    send_frame(80, 160, 1'b0, 1'b1, -1);
    check_status("t5");
    chk("t5_used2", 32'(used),      32'd2);
    chk("t5_len70", 32'(frame_len), 32'd70);
    read_head("t5_a");
    read_head("t5_b");
    check_status("t5_post");

    // Soft reset mid-frame clears everything and swallows the rest of the frame
    send_frame(64, 176, 1'b0, 1'b0, -1);
    send_frame(64, 192, 1'b0, 1'b0, 30);
    check_status("t6_srst");
    chk("t6_drop0", 32'(drop_cnt), 32'd0);
    chk("t6_err0",  32'(err_cnt),  32'd0);
    send_frame(64, 208, 1'b0, 1'b0, -1);
    check_status("t6");
    read_head("t6");
    check_status("t6_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
